// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, word size
// and the default halt encoding.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } ifu_state_e;

    localparam int unsigned WORD_BYTES        = 4;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFFFFFF;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// 32-bit program counter register: async reset value, load has priority over
// the sequential advance by one word.
import instruction_fetch_unit_pkg::*;

module program_counter #(
    parameter logic [31:0] RESET_VAL = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] load_val,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_VAL;
        else if (load)
            pc <= load_val;
        else if (en)
            pc <= pc + 32'(WORD_BYTES);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: IDLE/RUN/HALTED control FSM, program counter and the
// IF/ID pipeline register fed from a combinational instruction memory.
import instruction_fetch_unit_pkg::*;

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instruction,
    output logic [31:0] address,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pcplus4,
    output logic        ifid_valid,
    output logic        halted
);

    ifu_state_e  state_q, state_d;
    logic        pc_load, pc_en;
    logic        ifid_issue, ifid_flush, ifid_kill;
    logic [31:0] pc, pc_plus4, redirect_pc;

    assign pc_plus4    = pc + 32'(WORD_BYTES);
    assign redirect_pc = redirect_target & ~32'h3;
    assign address     = pc;

    program_counter #(.RESET_VAL(RESET_PC)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .en       (pc_en),
        .load_val (redirect_pc),
        .pc       (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= (state_d == ST_HALTED);
        end
    end

    // Redirect flushes even under stall; the halt word is never issued.
    always_comb begin
        state_d    = state_q;
        pc_load    = 1'b0;
        pc_en      = 1'b0;
        ifid_issue = 1'b0;
        ifid_flush = 1'b0;
        ifid_kill  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_load    = 1'b1;
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    pc_en = 1'b0;
                end else if (instruction == HALT_WORD) begin
                    state_d   = ST_HALTED;
                    ifid_kill = 1'b1;
                end else begin
                    pc_en      = 1'b1;
                    ifid_issue = 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instruction <= 32'h0;
            ifid_pcplus4     <= 32'h0;
            ifid_valid       <= 1'b0;
        end else if (ifid_flush) begin
            ifid_instruction <= 32'h0;
            ifid_valid       <= 1'b0;
        end else if (ifid_issue) begin
            ifid_instruction <= instruction;
            ifid_pcplus4     <= pc_plus4;
            ifid_valid       <= 1'b1;
        end else if (ifid_kill) begin
            ifid_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by randomized
// control traffic, all checked every cycle against a behavioural fetch model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] instruction;
    logic [31:0] address, ifid_instruction, ifid_pcplus4;
    logic        ifid_valid, halted;

    logic [31:0] mem [64];

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state: 0 idle, 1 running, 2 halted
    int          m_mode;
    logic [31:0] m_pc, m_ii, m_ip;
    logic        m_iv;

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .instruction      (instruction),
        .address          (address),
        .ifid_instruction (ifid_instruction),
        .ifid_pcplus4     (ifid_pcplus4),
        .ifid_valid       (ifid_valid),
        .halted           (halted)
    );

    always #5 clk = ~clk;
    always_comb instruction = mem[address[7:2]];

    task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk32({tag, ".address"}, address, m_pc);
        chk32({tag, ".ifid_instr"}, ifid_instruction, m_ii);
        chk32({tag, ".ifid_pc4"}, ifid_pcplus4, m_ip);
        chk32({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, m_iv});
        chk32({tag, ".halted"}, {31'h0, halted}, {31'h0, (m_mode == 2)});
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_ii = 32'h0; m_ip = 32'h0; m_iv = 1'b0;
    endtask

    task automatic step(input string tag, input logic s, input logic st,
                        input logic rd, input logic [31:0] tgt);
        logic [31:0] w;
        start = s; stall = st; redirect = rd; redirect_target = tgt;
        w = mem[m_pc[7:2]];
        if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (m_mode == 1) begin
            if (rd) begin
                m_pc = tgt & 32'hFFFF_FFFC; m_ii = 32'h0; m_iv = 1'b0;
            end else if (!st) begin
                if (w == 32'hFFFFFFFF) begin
                    m_mode = 2; m_iv = 1'b0;
                end else begin
                    m_ii = w; m_ip = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_iv = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset raised and checked between edges, released before the next edge.
    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == 32'hFFFFFFFF) mem[i] = 32'h1234_5678;
        end
        model_reset();
        #3;
        check_all("por");
        @(posedge clk); #1;
        reset = 1'b0;
        check_all("por_rel");

        // Sequential fetch from reset
        step("idle_stall_redir", 1'b0, 1'b1, 1'b1, 32'h80);
        chk32("idle_ignores_redirect", address, 32'h0);
        step("start", 1'b1, 1'b0, 1'b0, 32'h0);
        chk32("start_no_advance", address, 32'h0);
        step("adv0", 1'b0, 1'b0, 1'b0, 32'h0);
        chk32("adv0_addr", address, 32'h4);
        chk32("adv0_pc4", ifid_pcplus4, 32'h4);
        chk32("adv0_instr", ifid_instruction, mem[0]);
        step("adv1", 1'b0, 1'b0, 1'b0, 32'h0);
        chk32("adv1_addr", address, 32'h8);

        // Stall two cycles at 0x8
        step("stall0", 1'b0, 1'b1, 1'b0, 32'h0);
        step("stall1", 1'b0, 1'b1, 1'b0, 32'h0);
        chk32("stall_addr", address, 32'h8);
        chk32("stall_pc4", ifid_pcplus4, 32'h8);
        step("unstall", 1'b0, 1'b0, 1'b0, 32'h0);
        chk32("unstall_addr", address, 32'hC);

        // Async reset mid-run at 0xC, then idle until start
        @(negedge clk);
        reset_pulse("mid_reset");
        chk32("mid_reset_addr", address, 32'h0);
        for (int i = 0; i < 3; i++) step("post_reset_idle", 1'b0, 1'b1, 1'b1, 32'h40);
        chk32("post_reset_addr", address, 32'h0);

        // Restart, reach 0x10, redirect with stall
        step("restart", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step("to_0x10", 1'b0, 1'b0, 1'b0, 32'h0);
        step("redir_stall", 1'b0, 1'b1, 1'b1, 32'h0000_0042);
        chk32("redir_addr", address, 32'h40);
        chk32("redir_flush", {31'h0, ifid_valid}, 32'h0);
        step("after_redir", 1'b0, 1'b0, 1'b0, 32'h0);
        chk32("after_redir_pc4", ifid_pcplus4, 32'h44);
        chk32("after_redir_instr", ifid_instruction, mem[16]);

        // PC wrap-around
        step("redir_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, 1'b0, 32'h0);
        chk32("wrap_addr", address, 32'h0);
        chk32("wrap_pc4", ifid_pcplus4, 32'h0);

        // Halt word at 0x10
        mem[4] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) step("to_halt", 1'b0, 1'b0, 1'b0, 32'h0);
        step("halt", 1'b0, 1'b0, 1'b0, 32'h0);
        chk32("halt_flag", {31'h0, halted}, 32'h1);
        chk32("halt_addr", address, 32'h10);
        step("halt_start", 1'b1, 1'b0, 1'b0, 32'h0);
        step("halt_redir", 1'b0, 1'b1, 1'b1, 32'h100);
        chk32("halt_hold_addr", address, 32'h10);
        @(negedge clk);
        reset_pulse("halt_reset");

        // Randomized control traffic
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == 32'hFFFFFFFF) mem[i] = 32'h0;
            if ($urandom_range(0, 19) == 0) mem[i] = 32'hFFFFFFFF;
        end
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                @(negedge clk);
                reset_pulse("rnd_reset");
            end else begin
                step("rnd", ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 9) == 0), $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
